// File: rtl/battleship_pkg.sv
// Shared grid geometry, game constants, controller states and the cell-index
// helper for the battleships sequencing logic.
package battleship_pkg;

    localparam int GRID_W        = 10;
    localparam int GRID_H        = 10;
    localparam int SHIP_CELLS    = 17;
    localparam int QUERY_TIMEOUT = 15;
    localparam int ADDR_W        = $clog2(GRID_W * GRID_H);
    localparam int COORD_W       = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H);

    typedef enum logic [1:0] {
        AIM   = 2'd0,
        QUERY = 2'd1,
        MARK  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Row-major cell index; the grid width is passed in so overridden grids work.
    function automatic int cell_index(int x, int y, int grid_w);
        return y * grid_w + x;
    endfunction

endpackage

// File: rtl/cursor_ctrl.sv
// Saturating x/y aiming cursor. Opposing pulses in the same cycle cancel;
// x and y move independently, so diagonal steps are possible.
module cursor_ctrl #(
    parameter int MAX_X = 9,
    parameter int MAX_Y = 9,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         btn_l,
    input  logic         btn_r,
    input  logic         btn_u,
    input  logic         btn_d,
    output logic [W-1:0] x,
    output logic [W-1:0] y
);

    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en) begin
            if (btn_l && !btn_r && (x_q != '0))
                x_d = x_q - 1'b1;
            else if (btn_r && !btn_l && (x_q != W'(MAX_X)))
                x_d = x_q + 1'b1;
            // Row 0 is the top of the board, so "down" increments y.
            if (btn_u && !btn_d && (y_q != '0))
                y_d = y_q - 1'b1;
            else if (btn_d && !btn_u && (y_q != W'(MAX_Y)))
                y_d = y_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/shot_controller.sv
// Battleships shot sequencer: aims the cursor, runs a ship-map lookup per shot,
// writes one board mark per completed shot and keeps the packed score.
module shot_controller #(
    parameter int GRID_W        = battleship_pkg::GRID_W,
    parameter int GRID_H        = battleship_pkg::GRID_H,
    parameter int SHIP_CELLS    = battleship_pkg::SHIP_CELLS,
    parameter int QUERY_TIMEOUT = battleship_pkg::QUERY_TIMEOUT,
    localparam int ADDR_W       = $clog2(GRID_W * GRID_H),
    localparam int COORD_W      = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               btn_u,
    input  logic               btn_d,
    input  logic               btn_fire,
    input  logic               new_game,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               q_req,
    output logic [ADDR_W-1:0]  q_addr,
    input  logic               q_ack,
    input  logic               q_hit,
    output logic               mark_we,
    output logic [ADDR_W-1:0]  mark_addr,
    output logic               mark_hit,
    output logic [15:0]        score,
    output logic               game_over,
    output logic               busy
);

    import battleship_pkg::*;

    localparam int CELLS = GRID_W * GRID_H;
    localparam int TMO_W = $clog2(QUERY_TIMEOUT + 1);

    // Lookup handshake: q_req rises with q_addr valid and both stay frozen until
    // the responder pulses q_ack for one cycle, q_hit being valid in that cycle.
    // The request is withdrawn the cycle after the ack or after the timeout.
    state_t             state_q, state_d;
    logic [CELLS-1:0]   shot_map_q, shot_map_d;
    logic [7:0]         hits_q, hits_d;
    logic [7:0]         shots_q, shots_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               q_req_q, q_req_d;
    logic [ADDR_W-1:0]  q_addr_q, q_addr_d;
    logic               mark_we_q, mark_we_d;
    logic [ADDR_W-1:0]  mark_addr_q, mark_addr_d;
    logic               mark_hit_q, mark_hit_d;
    logic               busy_q, busy_d;
    logic               game_over_q, game_over_d;

    logic               restart;
    logic               move_en;
    logic [ADDR_W-1:0]  cur_addr;

    assign restart  = reset | new_game;
    assign move_en  = (state_q == AIM) && !btn_fire;
    assign cur_addr = ADDR_W'(cell_index(int'(cursor_x), int'(cursor_y), GRID_W));

    cursor_ctrl #(
        .MAX_X (GRID_W - 1),
        .MAX_Y (GRID_H - 1),
        .W     (COORD_W)
    ) u_cursor (
        .clk   (clk),
        .reset (restart),
        .en    (move_en),
        .btn_l (btn_l),
        .btn_r (btn_r),
        .btn_u (btn_u),
        .btn_d (btn_d),
        .x     (cursor_x),
        .y     (cursor_y)
    );

    always_comb begin
        state_d     = state_q;
        shot_map_d  = shot_map_q;
        hits_d      = hits_q;
        shots_d     = shots_q;
        tmo_d       = tmo_q;
        q_req_d     = q_req_q;
        q_addr_d    = q_addr_q;
        mark_we_d   = 1'b0;
        mark_addr_d = mark_addr_q;
        mark_hit_d  = mark_hit_q;
        busy_d      = busy_q;
        game_over_d = game_over_q;
        case (state_q)
            AIM: begin
                if (btn_fire && !shot_map_q[cur_addr]) begin
                    state_d  = QUERY;
                    q_req_d  = 1'b1;
                    q_addr_d = cur_addr;
                    tmo_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            QUERY: begin
                if (q_ack) begin
                    state_d     = MARK;
                    q_req_d     = 1'b0;
                    mark_we_d   = 1'b1;
                    mark_addr_d = q_addr_q;
                    mark_hit_d  = q_hit;
                end else if (tmo_q == TMO_W'(QUERY_TIMEOUT - 1)) begin
                    state_d = AIM;
                    q_req_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            MARK: begin
                shot_map_d[mark_addr_q] = 1'b1;
                shots_d = (shots_q == 8'hff) ? shots_q : shots_q + 8'd1;
                hits_d  = hits_q + {7'd0, mark_hit_q};
                busy_d  = 1'b0;
                if (hits_d == 8'(SHIP_CELLS)) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d = AIM;
                end
            end
            default: begin
                state_d = OVER;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q     <= AIM;
            shot_map_q  <= '0;
            hits_q      <= '0;
            shots_q     <= '0;
            tmo_q       <= '0;
            q_req_q     <= 1'b0;
            q_addr_q    <= '0;
            mark_we_q   <= 1'b0;
            mark_addr_q <= '0;
            mark_hit_q  <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shot_map_q  <= shot_map_d;
            hits_q      <= hits_d;
            shots_q     <= shots_d;
            tmo_q       <= tmo_d;
            q_req_q     <= q_req_d;
            q_addr_q    <= q_addr_d;
            mark_we_q   <= mark_we_d;
            mark_addr_q <= mark_addr_d;
            mark_hit_q  <= mark_hit_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign q_req     = q_req_q;
    assign q_addr    = q_addr_q;
    assign mark_we   = mark_we_q;
    assign mark_addr = mark_addr_q;
    assign mark_hit  = mark_hit_q;
    assign score     = {shots_q, hits_q};
    assign game_over = game_over_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shot_controller.sv
// Bench for shot_controller: a default instance and a SHIP_CELLS=2 instance,
// each checked every cycle against a transaction-level model of the game.
module tb_shot_controller;

    localparam int QT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  btn_l, btn_r, btn_u, btn_d, btn_fire, new_game;
    logic [1:0]  q_ack, q_hit;
    logic [1:0]  q_req, mark_we, mark_hit, game_over, busy;
    logic [3:0]  cursor_x [2];
    logic [3:0]  cursor_y [2];
    logic [6:0]  q_addr [2];
    logic [6:0]  mark_addr [2];
    logic [15:0] score [2];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    shot_controller u_dut0 (
        .clk(clk), .reset(reset),
        .btn_l(btn_l[0]), .btn_r(btn_r[0]), .btn_u(btn_u[0]), .btn_d(btn_d[0]),
        .btn_fire(btn_fire[0]), .new_game(new_game[0]),
        .cursor_x(cursor_x[0]), .cursor_y(cursor_y[0]),
        .q_req(q_req[0]), .q_addr(q_addr[0]), .q_ack(q_ack[0]), .q_hit(q_hit[0]),
        .mark_we(mark_we[0]), .mark_addr(mark_addr[0]), .mark_hit(mark_hit[0]),
        .score(score[0]), .game_over(game_over[0]), .busy(busy[0])
    );

    shot_controller #(.SHIP_CELLS(2)) u_dut1 (
        .clk(clk), .reset(reset),
        .btn_l(btn_l[1]), .btn_r(btn_r[1]), .btn_u(btn_u[1]), .btn_d(btn_d[1]),
        .btn_fire(btn_fire[1]), .new_game(new_game[1]),
        .cursor_x(cursor_x[1]), .cursor_y(cursor_y[1]),
        .q_req(q_req[1]), .q_addr(q_addr[1]), .q_ack(q_ack[1]), .q_hit(q_hit[1]),
        .mark_we(mark_we[1]), .mark_addr(mark_addr[1]), .mark_hit(mark_hit[1]),
        .score(score[1]), .game_over(game_over[1]), .busy(busy[1])
    );

    // ---------------- reference model ----------------
    int m_cx [2], m_cy [2], m_hits [2], m_shots [2], m_age [2], m_addr [2];
    bit m_inq [2], m_mark [2], m_mhit [2], m_over [2];
    bit m_shot [2][128];

    function automatic int clamp9(int v);
        return (v < 0) ? 0 : ((v > 9) ? 9 : v);
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_hits[i] = 0; m_shots[i] = 0;
            m_age[i] = 0; m_addr[i] = 0; m_inq[i] = 0; m_mark[i] = 0;
            m_mhit[i] = 0; m_over[i] = 0;
            for (int c = 0; c < 128; c++) m_shot[i][c] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                int sc;
                sc = (i == 0) ? 17 : 2;
                if (reset || new_game[i]) begin
                    m_cx[i] = 0; m_cy[i] = 0; m_hits[i] = 0; m_shots[i] = 0;
                    m_age[i] = 0; m_addr[i] = 0; m_inq[i] = 0; m_mark[i] = 0;
                    m_mhit[i] = 0; m_over[i] = 0;
                    for (int c = 0; c < 128; c++) m_shot[i][c] = 0;
                end else if (m_mark[i]) begin
                    m_shot[i][m_addr[i]] = 1;
                    if (m_shots[i] < 255) m_shots[i]++;
                    if (m_mhit[i]) m_hits[i]++;
                    m_over[i] = (m_hits[i] == sc);
                    m_mark[i] = 0;
                end else if (m_inq[i]) begin
                    if (q_ack[i]) begin
                        m_inq[i] = 0; m_mark[i] = 1; m_mhit[i] = q_hit[i];
                    end else if (m_age[i] == QT - 1) begin
                        m_inq[i] = 0;
                    end else begin
                        m_age[i]++;
                    end
                end else if (!m_over[i]) begin
                    if (btn_fire[i]) begin
                        int a;
                        a = m_cy[i] * 10 + m_cx[i];
                        if (!m_shot[i][a]) begin
                            m_inq[i] = 1; m_age[i] = 0; m_addr[i] = a;
                        end
                    end else begin
                        m_cx[i] = clamp9(m_cx[i] + int'(btn_r[i]) - int'(btn_l[i]));
                        m_cy[i] = clamp9(m_cy[i] + int'(btn_d[i]) - int'(btn_u[i]));
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[dut%0d] t=%0t got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    chk("cursor_x", i, 32'(cursor_x[i]), m_cx[i]);
                    chk("cursor_y", i, 32'(cursor_y[i]), m_cy[i]);
                    chk("q_req", i, 32'(q_req[i]), 32'(m_inq[i]));
                    if (m_inq[i]) chk("q_addr", i, 32'(q_addr[i]), m_addr[i]);
                    chk("mark_we", i, 32'(mark_we[i]), 32'(m_mark[i]));
                    if (m_mark[i]) begin
                        chk("mark_addr", i, 32'(mark_addr[i]), m_addr[i]);
                        chk("mark_hit", i, 32'(mark_hit[i]), 32'(m_mhit[i]));
                    end
                    chk("score", i, 32'(score[i]), (m_shots[i] << 8) | m_hits[i]);
                    chk("game_over", i, 32'(game_over[i]), 32'(m_over[i]));
                    chk("busy", i, 32'(busy[i]), 32'(m_inq[i] | m_mark[i]));
                end
            end
        end
    end

    // ---------------- ship-map responder ----------------
    int resp_delay [2] = '{-1, -1};
    int resp_cnt [2]   = '{0, 0};
    bit resp_hit [2]   = '{0, 0};
    bit force_ack [2]  = '{0, 0};

    initial begin
        q_ack = '0;
        q_hit = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                if (q_req[i]) begin
                    q_ack[i] = force_ack[i] || (resp_cnt[i] == resp_delay[i]);
                    resp_cnt[i]++;
                end else begin
                    resp_cnt[i] = 0;
                    q_ack[i] = force_ack[i];
                end
                q_hit[i] = resp_hit[i];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int i, input int b);
        case (b)
            0: btn_l[i] = 1'b1;
            1: btn_r[i] = 1'b1;
            2: btn_u[i] = 1'b1;
            3: btn_d[i] = 1'b1;
            default: btn_fire[i] = 1'b1;
        endcase
        tick();
        btn_l[i] = 1'b0; btn_r[i] = 1'b0; btn_u[i] = 1'b0; btn_d[i] = 1'b0;
        btn_fire[i] = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Fires at the cursor and observes a bounded window starting at N+1.
    task automatic shoot(input int i, input int dly, input bit hit,
                         output int reqs, output int marks, output int first_a,
                         output int ma, output int mh, output int mark_t, output int over_t);
        resp_delay[i] = dly;
        resp_hit[i] = hit;
        btn_fire[i] = 1'b1;
        tick();
        btn_fire[i] = 1'b0;
        reqs = 0; marks = 0; first_a = -1; ma = -1; mh = -1; mark_t = -1; over_t = -1;
        for (int k = 0; k < 40; k++) begin
            if (q_req[i]) begin
                if (reqs == 0) first_a = int'(q_addr[i]);
                reqs++;
            end
            if (mark_we[i]) begin
                marks++; ma = int'(mark_addr[i]); mh = int'(mark_hit[i]); mark_t = k;
            end
            if (game_over[i] && over_t < 0) over_t = k;
            tick();
        end
        resp_delay[i] = -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int reqs, marks, fa, ma, mh, mt, ot;
        reset = 1'b1;
        btn_l = '0; btn_r = '0; btn_u = '0; btn_d = '0; btn_fire = '0; new_game = '0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        lit("reset_cursor_x", 32'(cursor_x[0]), 0);
        lit("reset_score", 32'(score[0]), 0);
        lit("reset_game_over", 32'(game_over[1]), 0);

        // Movement and saturation on the default instance.
        repeat (3) press(0, 1);
        repeat (2) press(0, 3);
        lit("move_x3", 32'(cursor_x[0]), 3);
        lit("move_y2", 32'(cursor_y[0]), 2);
        repeat (12) press(0, 1);
        lit("sat_x9", 32'(cursor_x[0]), 9);
        btn_l[0] = 1'b1; btn_r[0] = 1'b1;
        tick();
        btn_l[0] = 1'b0; btn_r[0] = 1'b0;
        lit("lr_cancel_x", 32'(cursor_x[0]), 9);
        repeat (6) press(0, 0);

        // Hit at (3,2) with ack two cycles after the request rises.
        shoot(0, 2, 1'b1, reqs, marks, fa, ma, mh, mt, ot);
        lit("hit_q_addr", fa, 23);
        lit("hit_req_cycles", reqs, 3);
        lit("hit_marks", marks, 1);
        lit("hit_mark_addr", ma, 23);
        lit("hit_mark_hit", mh, 1);
        lit("hit_score", 32'(score[0]), 32'h0101);

        // Re-fire on an already shot cell is ignored.
        shoot(0, 0, 1'b1, reqs, marks, fa, ma, mh, mt, ot);
        lit("refire_req_cycles", reqs, 0);
        lit("refire_score", 32'(score[0]), 32'h0101);

        // Miss at (4,2) with an ack in the first request cycle.
        press(0, 1);
        shoot(0, 0, 1'b0, reqs, marks, fa, ma, mh, mt, ot);
        lit("miss_req_cycles", reqs, 1);
        lit("miss_mark_addr", ma, 24);
        lit("miss_mark_hit", mh, 0);
        lit("miss_score", 32'(score[0]), 32'h0201);

        // Timeout at (5,2), then a late ack, then a successful retry.
        press(0, 1);
        shoot(0, -1, 1'b0, reqs, marks, fa, ma, mh, mt, ot);
        lit("tmo_req_cycles", reqs, 15);
        lit("tmo_marks", marks, 0);
        lit("tmo_busy", 32'(busy[0]), 0);
        force_ack[0] = 1'b1; resp_hit[0] = 1'b1;
        tick();
        force_ack[0] = 1'b0;
        tick();
        lit("late_ack_score", 32'(score[0]), 32'h0201);
        shoot(0, 1, 1'b0, reqs, marks, fa, ma, mh, mt, ot);
        lit("retry_req_cycles", reqs, 2);
        lit("retry_mark_addr", ma, 25);
        lit("retry_score", 32'(score[0]), 32'h0301);

        // Game over on the SHIP_CELLS=2 instance.
        shoot(1, 1, 1'b1, reqs, marks, fa, ma, mh, mt, ot);
        lit("go_first_score", 32'(score[1]), 32'h0101);
        press(1, 1);
        shoot(1, 0, 1'b1, reqs, marks, fa, ma, mh, mt, ot);
        lit("go_latency", ot - mt, 1);
        lit("go_score", 32'(score[1]), 32'h0202);
        lit("go_flag", 32'(game_over[1]), 1);
        press(1, 1);
        press(1, 3);
        shoot(1, 0, 1'b1, reqs, marks, fa, ma, mh, mt, ot);
        lit("over_req_cycles", reqs, 0);
        lit("over_cursor_x", 32'(cursor_x[1]), 1);
        lit("over_score", 32'(score[1]), 32'h0202);
        new_game[1] = 1'b1;
        tick();
        new_game[1] = 1'b0;
        lit("ng_score", 32'(score[1]), 0);
        lit("ng_cursor_x", 32'(cursor_x[1]), 0);
        lit("ng_game_over", 32'(game_over[1]), 0);

        // Restart in the second QUERY cycle, followed by a stray ack.
        press(1, 1);
        press(1, 1);
        resp_delay[1] = -1;
        btn_fire[1] = 1'b1;
        tick();
        btn_fire[1] = 1'b0;
        tick();
        lit("mid_q_req_before", 32'(q_req[1]), 1);
        new_game[1] = 1'b1;
        tick();
        new_game[1] = 1'b0;
        lit("mid_q_req_after", 32'(q_req[1]), 0);
        lit("mid_busy", 32'(busy[1]), 0);
        force_ack[1] = 1'b1; resp_hit[1] = 1'b1;
        tick();
        force_ack[1] = 1'b0;
        lit("mid_mark_we", 32'(mark_we[1]), 0);
        tick();
        lit("mid_score", 32'(score[1]), 0);

        // Randomized play on both instances.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                btn_l[i] = ($urandom_range(0, 3) == 0);
                btn_r[i] = ($urandom_range(0, 3) == 0);
                btn_u[i] = ($urandom_range(0, 3) == 0);
                btn_d[i] = ($urandom_range(0, 3) == 0);
                btn_fire[i] = ($urandom_range(0, 7) == 0);
                if (btn_fire[i] && !busy[i]) begin
                    int r;
                    r = int'($urandom_range(0, 18));
                    resp_delay[i] = (r > 15) ? -1 : r;
                    resp_hit[i] = ($urandom_range(0, 1) == 1);
                end
                force_ack[i] = ($urandom_range(0, 15) == 0);
                new_game[i] = ($urandom_range(0, 149) == 0);
            end
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        btn_l = '0; btn_r = '0; btn_u = '0; btn_d = '0; btn_fire = '0; new_game = '0;
        force_ack[0] = 1'b0; force_ack[1] = 1'b0;
        reset = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
